// File: rtl/z80_bus_responder_if.sv
// Z80 pin-level bus plus backing req/ack port seen by the target-side responder.
// The slave modport is the responder; the master modport is the CPU/board side.
interface z80_bus_responder_if;
    logic        m1;
    logic        mreq;
    logic        iorq;
    logic        rd;
    logic        wr;
    logic        rfsh;
    logic        busack;
    logic [15:0] ab;
    logic [7:0]  db_in;
    logic [7:0]  db_out;
    logic        db_oe;
    logic        mwait;
    logic        intr;
    logic        irq;
    logic [7:0]  int_vector;
    logic        req;
    logic        req_we;
    logic        req_io;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        ack;
    logic [7:0]  rdata;

    modport slave (
        input  m1, mreq, iorq, rd, wr, rfsh, busack, ab, db_in, irq, int_vector, ack, rdata,
        output db_out, db_oe, mwait, intr, req, req_we, req_io, req_addr, req_wdata
    );

    modport master (
        output m1, mreq, iorq, rd, wr, rfsh, busack, ab, db_in, irq, int_vector, ack, rdata,
        input  db_out, db_oe, mwait, intr, req, req_we, req_io, req_addr, req_wdata
    );
endinterface

// File: rtl/z80_bus_responder.sv
// Classifies Z80 bus cycles, holds the CPU in WAIT while a backing access runs,
// and returns read data / interrupt vector. States:
//   IDLE    | no cycle in progress, watching strobes
//   DECODE  | cycle classified, address latched, WAIT asserted
//   SERVICE | backing req outstanding, waiting for ack
//   DATA    | data captured, burning remaining wait states
//   END     | WAIT released, waiting for the CPU to drop mreq/iorq
module z80_bus_responder #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    z80_bus_responder_if.slave bus
);
    localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_SERVICE, S_DATA, S_END} state_t;
    typedef enum logic [2:0] {C_RFSH, C_INTA, C_MRD, C_MWR, C_IORD, C_IOWR} kind_t;

    state_t        state_q, state_d;
    kind_t         kind_q, kind_d, kind_dec;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          pend_q, pend_d;
    logic          abort_q, abort_d;
    logic [7:0]    db_out_q, db_out_d;
    logic          mwait_q, mwait_d;
    logic          req_q, req_d;
    logic          req_we_q, req_we_d;
    logic          req_io_q, req_io_d;
    logic [15:0]   req_addr_q, req_addr_d;
    logic [7:0]    req_wdata_q, req_wdata_d;

    logic inta_strobe, start, inta_dec, aborted, kind_is_read;

    assign inta_strobe  = bus.m1 & bus.iorq;
    assign start        = ~bus.busack & (inta_strobe | bus.mreq | (bus.iorq & (bus.rd | bus.wr)));
    assign aborted      = abort_q | bus.busack;
    assign kind_is_read = (kind_q == C_MRD) || (kind_q == C_IORD) || (kind_q == C_INTA);

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        wcnt_d      = wcnt_q;
        abort_d     = abort_q;
        db_out_d    = db_out_q;
        mwait_d     = mwait_q;
        req_d       = req_q;
        req_we_d    = req_we_q;
        req_io_d    = req_io_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        inta_dec    = 1'b0;
        kind_dec    = C_RFSH;

        if (inta_strobe)                 kind_dec = C_INTA;
        else if (bus.mreq && bus.rfsh)   kind_dec = C_RFSH;
        else if (bus.mreq && bus.rd)     kind_dec = C_MRD;
        else if (bus.mreq)               kind_dec = C_MWR;
        else if (bus.rd)                 kind_dec = C_IORD;
        else                             kind_dec = C_IOWR;

        // Bus released mid-cycle: drop WAIT, let any backing access finish quietly.
        if (state_q != S_IDLE && bus.busack) begin
            abort_d = 1'b1;
            mwait_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    abort_d  = 1'b0;
                    wcnt_d   = CW'(WAIT_STATES);
                    kind_d   = kind_dec;
                    inta_dec = (kind_dec == C_INTA);
                    if (kind_dec == C_RFSH) begin
                        state_d = S_END;
                    end else begin
                        state_d    = S_DECODE;
                        mwait_d    = 1'b1;
                        req_addr_d = bus.ab;
                        if (kind_dec == C_MWR || kind_dec == C_IOWR) req_wdata_d = bus.db_in;
                    end
                end
            end
            S_DECODE: begin
                if (kind_q == C_INTA) begin
                    if (aborted) begin
                        state_d = S_IDLE;
                    end else begin
                        db_out_d = bus.int_vector;
                        state_d  = S_DATA;
                    end
                end else begin
                    req_d    = 1'b1;
                    req_we_d = (kind_q == C_MWR) || (kind_q == C_IOWR);
                    req_io_d = (kind_q == C_IORD) || (kind_q == C_IOWR);
                    state_d  = S_SERVICE;
                end
            end
            S_SERVICE: begin
                if (bus.ack) begin
                    req_d = 1'b0;
                    if (kind_is_read) db_out_d = bus.rdata;
                    state_d = aborted ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (aborted) begin
                    state_d = S_IDLE;
                end else if (wcnt_q <= CW'(1)) begin
                    wcnt_d  = '0;
                    mwait_d = 1'b0;
                    state_d = S_END;
                end else begin
                    wcnt_d = wcnt_q - CW'(1);
                end
            end
            S_END: begin
                if (aborted || (!bus.mreq && !bus.iorq)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        pend_d = bus.irq | (pend_q & ~inta_dec);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            kind_q      <= C_RFSH;
            wcnt_q      <= '0;
            pend_q      <= 1'b0;
            abort_q     <= 1'b0;
            db_out_q    <= 8'h00;
            mwait_q     <= 1'b0;
            req_q       <= 1'b0;
            req_we_q    <= 1'b0;
            req_io_q    <= 1'b0;
            req_addr_q  <= 16'h0000;
            req_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            wcnt_q      <= wcnt_d;
            pend_q      <= pend_d;
            abort_q     <= abort_d;
            db_out_q    <= db_out_d;
            mwait_q     <= mwait_d;
            req_q       <= req_d;
            req_we_q    <= req_we_d;
            req_io_q    <= req_io_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
        end
    end

    // Output enable follows the CPU strobes combinationally so the pins release
    // in the same cycle the CPU stops reading.
    assign bus.db_oe     = ((state_q == S_DATA) || (state_q == S_END)) & kind_is_read
                           & (bus.rd | inta_strobe) & ~bus.busack & ~abort_q;
    assign bus.db_out    = db_out_q;
    assign bus.mwait     = mwait_q & ~bus.busack;
    assign bus.intr      = pend_q;
    assign bus.req       = req_q;
    assign bus.req_we    = req_we_q;
    assign bus.req_io    = req_io_q;
    assign bus.req_addr  = req_addr_q;
    assign bus.req_wdata = req_wdata_q;
endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: two instances (0 and 3 wait states),
// a timestamp-based reference model for the zero-wait instance, and literal checks.
module tb_z80_bus_responder;
    localparam int WS0 = 0;
    localparam int MX0 = (WS0 > 1) ? WS0 : 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v = 1'b1;
    logic        m1_v = 0, mreq_v = 0, iorq_v = 0, rd_v = 0, wr_v = 0, rfsh_v = 0, busack_v = 0;
    logic        irq_v = 0;
    logic [15:0] ab_v = 16'h0000;
    logic [7:0]  dbin_v = 8'h00, ivec_v = 8'h00, rdata_v = 8'h00;
    logic        man_ack = 0, ack0a = 0, ack3a = 0, auto_en = 1;
    int          ack_lat = 0, cnt0 = 0, cnt3 = 0;

    z80_bus_responder_if bus0 ();
    z80_bus_responder_if bus3 ();

    assign bus0.m1 = m1_v;       assign bus3.m1 = m1_v;
    assign bus0.mreq = mreq_v;   assign bus3.mreq = mreq_v;
    assign bus0.iorq = iorq_v;   assign bus3.iorq = iorq_v;
    assign bus0.rd = rd_v;       assign bus3.rd = rd_v;
    assign bus0.wr = wr_v;       assign bus3.wr = wr_v;
    assign bus0.rfsh = rfsh_v;   assign bus3.rfsh = rfsh_v;
    assign bus0.busack = busack_v; assign bus3.busack = busack_v;
    assign bus0.ab = ab_v;       assign bus3.ab = ab_v;
    assign bus0.db_in = dbin_v;  assign bus3.db_in = dbin_v;
    assign bus0.irq = irq_v;     assign bus3.irq = irq_v;
    assign bus0.int_vector = ivec_v; assign bus3.int_vector = ivec_v;
    assign bus0.rdata = rdata_v; assign bus3.rdata = rdata_v;
    assign bus0.ack = ack0a | man_ack;
    assign bus3.ack = ack3a | man_ack;

    z80_bus_responder #(.WAIT_STATES(WS0)) dut0 (.clk_i(clk), .reset_i(rst_v), .bus(bus0));
    z80_bus_responder #(.WAIT_STATES(3))   dut3 (.clk_i(clk), .reset_i(rst_v), .bus(bus3));

    int errs = 0, checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Backing store: ack arrives after ack_lat cycles of req being seen high.
    initial forever begin
        @(negedge clk);
        if (auto_en && bus0.req && !ack0a) begin
            if (cnt0 >= ack_lat) begin ack0a = 1; cnt0 = 0; end else cnt0++;
        end else begin
            ack0a = 0;
            if (!bus0.req) cnt0 = 0;
        end
        if (auto_en && bus3.req && !ack3a) begin
            if (cnt3 >= ack_lat) begin ack3a = 1; cnt3 = 0; end else cnt3++;
        end else begin
            ack3a = 0;
            if (!bus3.req) cnt3 = 0;
        end
    end

    // Reference model for the zero-wait instance, driven by edge timestamps:
    // t0 = decode edge, tdata = edge data became available, tend = WAIT release edge.
    int          cyc = 0, t0 = 0, tdata = -1, tend = -1;
    bit          active = 0, linger = 0, was_idle, inta_now;
    bit          e_isrd = 0, e_isinta = 0, e_req = 0, e_we = 0, e_io = 0, e_mwait = 0, e_pend = 0, e_oe;
    logic [7:0]  e_db = 0, e_wd = 0;
    logic [15:0] e_addr = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst_v) begin
            active = 0; linger = 0; e_req = 0; e_mwait = 0; e_pend = 0; e_we = 0; e_io = 0;
            e_isrd = 0; e_db = 0; e_wd = 0; e_addr = 0; tdata = -1; tend = -1;
        end else begin
            was_idle = !active && !linger;
            inta_now = was_idle && !busack_v && m1_v && iorq_v;
            e_pend   = irq_v || (e_pend && !inta_now);
            if (linger) begin
                if (!mreq_v && !iorq_v) begin linger = 0; tdata = -1; end
            end else if (active) begin
                if (cyc == t0 + 1) begin
                    if (e_isinta) begin e_db = ivec_v; tdata = cyc; tend = cyc + MX0; end
                    else e_req = 1;
                end else if (e_req && bus0.ack) begin
                    e_req = 0; tdata = cyc; tend = cyc + MX0;
                    if (e_isrd) e_db = rdata_v;
                end
                if (cyc == tend) begin e_mwait = 0; active = 0; linger = 1; end
            end else if (!busack_v && ((m1_v && iorq_v) || mreq_v || (iorq_v && (rd_v || wr_v)))) begin
                t0 = cyc; tdata = -1; tend = -1;
                e_isinta = m1_v && iorq_v;
                if (!e_isinta && mreq_v && rfsh_v) begin
                    linger = 1; e_isrd = 0;
                end else begin
                    active = 1; e_mwait = 1; e_addr = ab_v;
                    e_isrd = e_isinta || rd_v;
                    e_we   = !e_isrd;
                    e_io   = !e_isinta && !mreq_v;
                    if (e_we) e_wd = dbin_v;
                end
            end
        end
    end

    bit cmp_en = 0;
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            e_oe = (tdata >= 0) && (active || linger) && e_isrd && (rd_v || (m1_v && iorq_v)) && !busack_v;
            chk("req", bus0.req, e_req);
            chk("mwait", bus0.mwait, e_mwait);
            chk("intr", bus0.intr, e_pend);
            chk("db_out", bus0.db_out, e_db);
            chk("db_oe", bus0.db_oe, e_oe);
            chk("req_addr", bus0.req_addr, e_addr);
            chk("req_wdata", bus0.req_wdata, e_wd);
            if (e_req) begin
                chk("req_we", bus0.req_we, e_we);
                chk("req_io", bus0.req_io, e_io);
            end
        end
    end

    int w0, w3, rq0, rise0;
    bit oe0, we0, io3;

    task automatic run_cycle(input logic vm1, vmreq, viorq, vrd, vwr, vrfsh, virq,
                             input logic [15:0] a, input logic [7:0] d);
        logic prev = 0;
        @(posedge clk); #2;
        m1_v = vm1; mreq_v = vmreq; iorq_v = viorq; rd_v = vrd; wr_v = vwr; rfsh_v = vrfsh;
        irq_v = virq; ab_v = a; dbin_v = d;
        w0 = 0; w3 = 0; rq0 = 0; rise0 = 0; oe0 = 0; we0 = 0; io3 = 0;
        @(posedge clk); #2 irq_v = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus0.mwait) w0++;
            if (bus3.mwait) w3++;
            if (bus0.req) begin rq0++; if (bus0.req_we) we0 = 1; end
            if (bus0.req && !prev) rise0++;
            prev = bus0.req;
            if (bus0.db_oe) oe0 = 1;
            if (bus3.req && bus3.req_io) io3 = 1;
        end
        @(posedge clk); #2;
        m1_v = 0; mreq_v = 0; iorq_v = 0; rd_v = 0; wr_v = 0; rfsh_v = 0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        @(posedge clk); #2 cmp_en = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_db_out", bus0.db_out, 8'h00);
        chk("rst_req_addr", bus0.req_addr, 16'h0000);
        chk("rst_mwait", bus0.mwait, 1'b0);
        chk("rst_intr", bus0.intr, 1'b0);
        @(posedge clk); #2 rst_v = 0;

        // Memory read, ack one cycle after req is seen.
        ack_lat = 1; rdata_v = 8'hA5;
        run_cycle(0, 1, 0, 1, 0, 0, 0, 16'h1234, 8'h00);
        chk("mrd_mwait_len", w0, 4);
        chk("mrd_req_len", rq0, 2);
        chk("mrd_req_count", rise0, 1);
        chk("mrd_addr", bus0.req_addr, 16'h1234);
        chk("mrd_data", bus0.db_out, 8'hA5);
        chk("mrd_oe_seen", oe0, 1'b1);

        // Memory write decoded on mreq alone.
        run_cycle(0, 1, 0, 0, 0, 0, 0, 16'h8000, 8'h3C);
        chk("mwr_wdata", bus0.req_wdata, 8'h3C);
        chk("mwr_we", we0, 1'b1);
        chk("mwr_req_count", rise0, 1);
        chk("mwr_no_oe", oe0, 1'b0);

        // I/O read with immediate ack on both instances.
        ack_lat = 0; rdata_v = 8'h5A;
        run_cycle(0, 0, 1, 1, 0, 0, 0, 16'h0042, 8'h00);
        chk("iord_mwait_ws3", w3, 5);
        chk("iord_mwait_ws0", w0, 3);
        chk("iord_req_io", io3, 1'b1);
        chk("iord_data_ws3", bus3.db_out, 8'h5A);
        chk("iord_data_ws0", bus0.db_out, 8'h5A);

        // Interrupt request then acknowledge.
        @(posedge clk); #2 irq_v = 1;
        @(posedge clk); #2 irq_v = 0;
        @(negedge clk);
        chk("irq_intr", bus0.intr, 1'b1);
        ivec_v = 8'hFE;
        run_cycle(1, 0, 1, 0, 0, 0, 0, 16'h0038, 8'h00);
        chk("inta_no_req", rise0, 0);
        chk("inta_vector", bus0.db_out, 8'hFE);
        chk("inta_intr_clr", bus0.intr, 1'b0);
        chk("inta_oe", oe0, 1'b1);
        chk("inta_mwait_len", w0, 2);

        // irq coinciding with the acknowledge decode keeps the request pending.
        run_cycle(1, 0, 1, 0, 0, 0, 1, 16'h0038, 8'h00);
        chk("inta_set_wins", bus0.intr, 1'b1);

        // Refresh is ignored entirely.
        run_cycle(0, 1, 0, 0, 0, 1, 0, 16'h007F, 8'h00);
        chk("rfsh_no_req", rise0, 0);
        chk("rfsh_no_wait", w0, 0);
        chk("rfsh_addr_kept", bus0.req_addr, 16'h0038);

        // Reset while SERVICE is waiting for ack; a late ack must be ignored.
        auto_en = 0; rdata_v = 8'h77;
        @(posedge clk); #2;
        mreq_v = 1; rd_v = 1; ab_v = 16'h4444;
        repeat (3) @(posedge clk);
        #2 rst_v = 1; mreq_v = 0; rd_v = 0;
        @(negedge clk);
        chk("svc_req_before_rst", bus0.req, 1'b1);
        @(negedge clk);
        chk("rst_req_drop", bus0.req, 1'b0);
        chk("rst_mwait_drop", bus0.mwait, 1'b0);
        chk("rst_intr_clr", bus0.intr, 1'b0);
        @(posedge clk); #2 rst_v = 0; man_ack = 1;
        @(posedge clk); #2 man_ack = 0;
        @(negedge clk);
        chk("late_ack_db", bus0.db_out, 8'h00);
        chk("late_ack_req", bus0.req, 1'b0);
        chk("late_ack_mwait", bus0.mwait, 1'b0);

        // Back in IDLE: a fresh read is serviced normally.
        auto_en = 1; ack_lat = 0; rdata_v = 8'h11;
        run_cycle(0, 1, 0, 1, 0, 0, 0, 16'h2222, 8'h00);
        chk("post_rst_data", bus0.db_out, 8'h11);
        chk("post_rst_req_count", rise0, 1);
        chk("post_rst_addr", bus0.req_addr, 16'h2222);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
